// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU constants, fetch state encoding and CHR address helper
package ppu_pkg;

  localparam int CHR_ROM_WIDTH = 13;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LO_ADDR = 3'd1,
    ST_LO_DATA = 3'd2,
    ST_HI_ADDR = 3'd3,
    ST_HI_DATA = 3'd4,
    ST_FULL    = 3'd5
  } fetch_state_t;

  // Pattern byte address: {table, tile, plane, fine_y}; plane 0 = low bitplane.
  function automatic logic [CHR_ROM_WIDTH-1:0] chr_pattern_addr(
    input logic       tbl,
    input logic [7:0] tile,
    input logic       plane,
    input logic [2:0] fy
  );
    return {tbl, tile, plane, fy};
  endfunction

endpackage

// File: rtl/bg_shifter.sv
// rtl/bg_shifter.sv - 16-bit background shifter with parallel load of the low byte
module bg_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clk_en,
  input  logic        i_shift_en,
  input  logic        i_load,
  input  logic [7:0]  i_load_data,
  output logic [15:0] o_q
);

  logic [15:0] r_q;
  logic [15:0] w_shifted;

  // A load in the same dot as a shift keeps the shifted high byte and replaces the low byte.
  assign w_shifted = i_shift_en ? {r_q[14:0], 1'b0} : r_q;
  assign o_q       = r_q;

  // Advance only on PPU dots; load overrides the low byte after any shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clk_en) begin
      if (i_load) begin
        r_q <= {w_shifted[15:8], i_load_data};
      end else begin
        r_q <= w_shifted;
      end
    end
  end

endmodule

// File: rtl/chr_tile_fetcher.sv
// rtl/chr_tile_fetcher.sv - background tile pattern fetch and pixel shifter engine (option: BG_FINE_X_EN)
module chr_tile_fetcher
  import ppu_pkg::*;
#(
  parameter int CHR_AW = 13,
  parameter int ATTR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_tile,
  input  logic [2:0]        req_fine_y,
  input  logic              req_table,
  input  logic [ATTR_W-1:0] req_attr,
  output logic [CHR_AW-1:0] chr_addr,
  input  logic [7:0]        chr_data,
  input  logic              load,
  input  logic              shift_en,
  input  logic [2:0]        fine_x,
  output logic [3:0]        pix,
  output logic              underrun
);

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic              w_req_ready;
  logic              w_issue_lo;
  logic              w_cap_lo;
  logic              w_cap_hi;
  logic              w_full;

  logic [7:0]        r_tile;
  logic [2:0]        r_fine_y;
  logic              r_table;
  logic [ATTR_W-1:0] r_attr;
  logic [CHR_AW-1:0] r_chr_addr;
  logic [7:0]        r_lo_buf;
  logic [7:0]        r_hi_buf;
  logic              r_underrun;

  logic [7:0]        w_pt_lo_din;
  logic [7:0]        w_pt_hi_din;
  logic [7:0]        w_at_lo_din;
  logic [7:0]        w_at_hi_din;
  logic [15:0]       w_pt_lo;
  logic [15:0]       w_pt_hi;
  logic [15:0]       w_at_lo;
  logic [15:0]       w_at_hi;
  logic [3:0]        w_tap;

  assign w_full    = (r_state == ST_FULL);
  assign req_ready = w_req_ready;
  assign chr_addr  = r_chr_addr;
  assign underrun  = r_underrun;

  // Fetch state register; moves only on PPU dots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (clk_en) begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus per-state strobes for address issue and data capture.
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_issue_lo  = 1'b0;
    w_cap_lo    = 1'b0;
    w_cap_hi    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          w_next     = ST_LO_ADDR;
          w_issue_lo = 1'b1;
        end
      end
      ST_LO_ADDR: w_next = ST_LO_DATA;
      ST_LO_DATA: begin
        w_next   = ST_HI_ADDR;
        w_cap_lo = 1'b1;
      end
      ST_HI_ADDR: w_next = ST_HI_DATA;
      ST_HI_DATA: begin
        w_next   = ST_FULL;
        w_cap_hi = 1'b1;
      end
      ST_FULL: begin
        if (load) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, ROM address sequencing, bitplane capture and underrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tile     <= '0;
      r_fine_y   <= '0;
      r_table    <= 1'b0;
      r_attr     <= '0;
      r_chr_addr <= '0;
      r_lo_buf   <= '0;
      r_hi_buf   <= '0;
      r_underrun <= 1'b0;
    end else if (clk_en) begin
      r_underrun <= load & ~w_full;
      if (w_issue_lo) begin
        r_tile     <= req_tile;
        r_fine_y   <= req_fine_y;
        r_table    <= req_table;
        r_attr     <= req_attr;
        r_chr_addr <= CHR_AW'(chr_pattern_addr(req_table, req_tile, 1'b0, req_fine_y));
      end
      if (w_cap_lo) begin
        r_lo_buf   <= chr_data;
        r_chr_addr <= CHR_AW'(chr_pattern_addr(r_table, r_tile, 1'b1, r_fine_y));
      end
      if (w_cap_hi) begin
        r_hi_buf <= chr_data;
      end
    end
  end

  // Only a completed fetch reaches the shifters; otherwise the new tile is blank.
  assign w_pt_lo_din = w_full ? r_lo_buf : 8'h00;
  assign w_pt_hi_din = w_full ? r_hi_buf : 8'h00;
  assign w_at_lo_din = w_full ? {8{r_attr[0]}} : 8'h00;
  assign w_at_hi_din = w_full ? {8{r_attr[1]}} : 8'h00;

  bg_shifter u_pt_lo (
    .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_shift_en(shift_en),
    .i_load(load), .i_load_data(w_pt_lo_din), .o_q(w_pt_lo)
  );

  bg_shifter u_pt_hi (
    .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_shift_en(shift_en),
    .i_load(load), .i_load_data(w_pt_hi_din), .o_q(w_pt_hi)
  );

  bg_shifter u_at_lo (
    .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_shift_en(shift_en),
    .i_load(load), .i_load_data(w_at_lo_din), .o_q(w_at_lo)
  );

  bg_shifter u_at_hi (
    .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_shift_en(shift_en),
    .i_load(load), .i_load_data(w_at_hi_din), .o_q(w_at_hi)
  );

`ifdef BG_FINE_X_EN
  assign w_tap = 4'd15 - {1'b0, fine_x};
`else
  logic w_unused_fine_x;
  assign w_unused_fine_x = ^fine_x;
  assign w_tap = 4'd15;
`endif

  assign pix = {w_at_hi[w_tap], w_at_lo[w_tap], w_pt_hi[w_tap], w_pt_lo[w_tap]};

endmodule

// File: tb/tb_chr_tile_fetcher.sv
// tb/tb_chr_tile_fetcher.sv - scoreboard bench for chr_tile_fetcher with behavioural reference model
module tb_chr_tile_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_tile;
  logic [2:0]  req_fine_y;
  logic        req_table;
  logic [1:0]  req_attr;
  logic [12:0] chr_addr;
  logic [7:0]  chr_data;
  logic        load;
  logic        shift_en;
  logic [2:0]  fine_x;
  logic [3:0]  pix;
  logic        underrun;

  chr_tile_fetcher #(.CHR_AW(13), .ATTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tile(req_tile), .req_fine_y(req_fine_y), .req_table(req_table), .req_attr(req_attr),
    .chr_addr(chr_addr), .chr_data(chr_data),
    .load(load), .shift_en(shift_en), .fine_x(fine_x),
    .pix(pix), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Synchronous CHR ROM: data one clock after the address.
  logic [7:0] rom [0:8191];
  always @(posedge clk) chr_data <= rom[chr_addr];

`ifdef BG_FINE_X_EN
  localparam bit FINE_TAP_EN = 1'b1;
`else
  localparam bit FINE_TAP_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  pix;
    logic        und;
    logic        rdy;
    logic [12:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: a fetch is "busy" from acceptance until its load,
  // and its bytes are ready four dots after acceptance.
  logic [15:0] m_pt_lo, m_pt_hi, m_at_lo, m_at_hi;
  bit          m_busy;
  int          m_age;
  logic [7:0]  m_lo, m_hi;
  logic [1:0]  m_attr;
  logic [12:0] m_addr, m_lo_addr, m_hi_addr;
  logic        m_under;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pt_lo = '0; m_pt_hi = '0; m_at_lo = '0; m_at_hi = '0;
    m_busy = 0; m_age = 0; m_lo = '0; m_hi = '0; m_attr = '0;
    m_addr = '0; m_lo_addr = '0; m_hi_addr = '0; m_under = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] t, input logic [2:0] fy,
                            input logic tb, input logic [1:0] a, input logic ld, input logic sh);
    bit full;
    bit busy_before;
    full        = m_busy && (m_age >= 4);
    busy_before = m_busy;
    if (sh) begin
      m_pt_lo = m_pt_lo << 1; m_pt_hi = m_pt_hi << 1;
      m_at_lo = m_at_lo << 1; m_at_hi = m_at_hi << 1;
    end
    if (ld) begin
      m_pt_lo[7:0] = full ? m_lo : 8'h00;
      m_pt_hi[7:0] = full ? m_hi : 8'h00;
      m_at_lo[7:0] = (full && m_attr[0]) ? 8'hFF : 8'h00;
      m_at_hi[7:0] = (full && m_attr[1]) ? 8'hFF : 8'h00;
      m_under = !full;
      if (full) m_busy = 0;
    end else begin
      m_under = 1'b0;
    end
    if (!busy_before && v) begin
      m_busy    = 1;
      m_age     = 0;
      m_lo_addr = {tb, t, 1'b0, fy};
      m_hi_addr = {tb, t, 1'b1, fy};
      m_lo      = rom[m_lo_addr];
      m_hi      = rom[m_hi_addr];
      m_attr    = a;
      m_addr    = m_lo_addr;
    end else if (m_busy && m_age < 4) begin
      m_age++;
      if (m_age == 2) m_addr = m_hi_addr;
    end
  endtask

  function automatic logic [3:0] model_pix(input logic [2:0] fx);
    int tap;
    tap = 15 - (FINE_TAP_EN ? int'(fx) : 0);
    return {m_at_hi[tap], m_at_lo[tap], m_pt_hi[tap], m_pt_lo[tap]};
  endfunction

  // One PPU dot: clk_en high for one clock out of four, expectation queued for the monitor.
  task automatic dot(input logic v, input logic [7:0] t, input logic [2:0] fy, input logic tb,
                     input logic [1:0] a, input logic ld, input logic sh, input logic [2:0] fx);
    exp_t e;
    @(negedge clk);
    req_valid = v; req_tile = t; req_fine_y = fy; req_table = tb; req_attr = a;
    load = ld; shift_en = sh; fine_x = fx; clk_en = 1'b1;
    model_step(v, t, fy, tb, a, ld, sh);
    e.pix  = model_pix(fx);
    e.und  = m_under;
    e.rdy  = !m_busy;
    e.addr = m_addr;
    sb_q.push_back(e);
    @(negedge clk);
    clk_en = 1'b0; req_valid = 1'b0; load = 1'b0; shift_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic idle_dot();
    dot(1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0);
  endtask

  // Monitor: after every enabled edge, pop the next expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (clk_en === 1'b1 && rst_n === 1'b1) begin
        #1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=empty required=entry");
        end else begin
          e = sb_q.pop_front();
          chk("pix", {28'd0, pix}, {28'd0, e.pix});
          chk("underrun", {31'd0, underrun}, {31'd0, e.und});
          chk("req_ready", {31'd0, req_ready}, {31'd0, e.rdy});
          chk("chr_addr", {19'd0, chr_addr}, {19'd0, e.addr});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  logic [3:0] seq [0:7];

  initial begin
    seq[0] = 4'h9; seq[1] = 4'h8; seq[2] = 4'hB; seq[3] = 4'hA;
    seq[4] = 4'hA; seq[5] = 4'hB; seq[6] = 4'h8; seq[7] = 4'h9;
    for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);
    rom[13'h1245] = 8'hA5;
    rom[13'h124D] = 8'h3C;
    rst_n = 1'b0; clk_en = 1'b0; req_valid = 1'b0; req_tile = '0; req_fine_y = '0;
    req_table = 1'b0; req_attr = '0; load = 1'b0; shift_en = 1'b0; fine_x = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_chr_addr", {19'd0, chr_addr}, 32'd0);
    chk("rst_pix", {28'd0, pix}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    rst_n = 1'b1;

    // Tile 0x24, table 1, fine Y 5: low plane address for two dots, then high plane.
    dot(1'b1, 8'h24, 3'd5, 1'b1, 2'b10, 1'b0, 1'b0, 3'd0);
    chk("t1_addr_lo_a", {19'd0, chr_addr}, 32'h1245);
    idle_dot();
    chk("t1_addr_lo_b", {19'd0, chr_addr}, 32'h1245);
    idle_dot();
    chk("t1_addr_hi", {19'd0, chr_addr}, 32'h124D);
    idle_dot();
    idle_dot();
    chk("t1_busy_full", {31'd0, req_ready}, 32'd0);

    // Load the completed tile and shift it out to the tap.
    dot(1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0);
    chk("t2_no_underrun", {31'd0, underrun}, 32'd0);
    for (int k = 0; k < 15; k++) begin
      dot(1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0);
      if (k >= 7) chk("t2_pix_seq", {28'd0, pix}, {28'd0, seq[k-7]});
    end

    // Load while the low plane is still being fetched.
    dot(1'b1, 8'h24, 3'd5, 1'b1, 2'b10, 1'b0, 1'b0, 3'd0);
    idle_dot();
    dot(1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0);
    chk("t3_underrun", {31'd0, underrun}, 32'd1);
    idle_dot();
    chk("t3_underrun_pulse", {31'd0, underrun}, 32'd0);
    idle_dot();
    idle_dot();
    dot(1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0);
    chk("t3_late_load_ok", {31'd0, underrun}, 32'd0);
    for (int k = 0; k < 8; k++) dot(1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0);

    // Reset in the middle of a fetch with live shifter contents.
    dot(1'b1, 8'h24, 3'd5, 1'b1, 2'b10, 1'b0, 1'b0, 3'd0);
    idle_dot();
    idle_dot();
    chk("t6_pre_pix", {28'd0, pix}, 32'h9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
    chk("t6_chr_addr", {19'd0, chr_addr}, 32'd0);
    chk("t6_pix", {28'd0, pix}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic: requests, loads at arbitrary phases, shifts and fine X.
    for (int n = 0; n < 400; n++) begin
      dot(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom), 1'($urandom),
          2'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0),
          3'($urandom));
    end

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
